// File: rtl/issue_queue_pkg.sv
// Shared definitions for the dual-issue instruction queue.
//   - META_W and the bit offsets of the metadata word
//     {is_priv, is_alu, rd[4:0], rj[4:0], rk[4:0]}
//   - FSM state encoding (RUN / HOLD)
//   - NOP constant driven on any slot that does not issue
//   - small field-extraction helpers
package issue_queue_pkg;

    localparam int META_W   = 17;
    localparam int REG_W    = 5;
    localparam int RK_LSB   = 0;
    localparam int RJ_LSB   = 5;
    localparam int RD_LSB   = 10;
    localparam int ALU_BIT  = 15;
    localparam int PRIV_BIT = 16;

    // A slot that does not issue carries all-zero metadata; the payload of
    // such a slot is likewise all-zero (replicated from NOP_BIT).
    localparam logic [META_W-1:0] NOP_META = '0;
    localparam logic              NOP_BIT  = 1'b0;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } iq_state_e;

    function automatic logic [REG_W-1:0] meta_rd(input logic [META_W-1:0] m);
        return m[RD_LSB +: REG_W];
    endfunction

    function automatic logic [REG_W-1:0] meta_rj(input logic [META_W-1:0] m);
        return m[RJ_LSB +: REG_W];
    endfunction

    function automatic logic [REG_W-1:0] meta_rk(input logic [META_W-1:0] m);
        return m[RK_LSB +: REG_W];
    endfunction

    function automatic logic meta_priv(input logic [META_W-1:0] m);
        return m[PRIV_BIT];
    endfunction

    function automatic logic meta_alu(input logic [META_W-1:0] m);
        return m[ALU_BIT];
    endfunction

endpackage

// File: rtl/issue_pair_check.sv
// Decides whether the two oldest queue entries may issue together.
// Ports:
//   meta0   in  META_W  metadata of the older entry (slot0)
//   meta1   in  META_W  metadata of the younger entry (slot1)
//   dual_ok out 1       both are non-privileged ALU ops writing distinct,
//                       non-zero destinations with no RAW/WAR hazard
//                       between them
// Occupancy and FSM state are qualified by the caller.
module issue_pair_check
    import issue_queue_pkg::*;
(
    input  logic [META_W-1:0] meta0,
    input  logic [META_W-1:0] meta1,
    output logic              dual_ok
);

    logic [REG_W-1:0] rd0, rj0, rk0;
    logic [REG_W-1:0] rd1, rj1, rk1;
    logic             kinds_ok;
    logic             regs_ok;

    assign rd0 = meta_rd(meta0);
    assign rj0 = meta_rj(meta0);
    assign rk0 = meta_rk(meta0);
    assign rd1 = meta_rd(meta1);
    assign rj1 = meta_rj(meta1);
    assign rk1 = meta_rk(meta1);

    assign kinds_ok = meta_alu(meta0) && meta_alu(meta1) &&
                      !meta_priv(meta0) && !meta_priv(meta1);

    // rd==0 is excluded outright so r0 writes never have to be reasoned
    // about as a hazard.
    assign regs_ok = (rd0 != '0) && (rd1 != '0) &&
                     (rd0 != rj1) && (rd0 != rk1) && (rd0 != rd1) &&
                     (rd1 != rj0) && (rd1 != rk0);

    assign dual_ok = kinds_ok && regs_ok;

endmodule

// File: rtl/issue_queue.sv
// Two-wide in-order issue queue (circular buffer) between decode and the
// register-read stage.
// Ports:
//   clk        in   1       rising-edge clock
//   rstn       in   1       asynchronous active-low reset
//   flush      in   1       discard every entry; wins over enqueue and pop
//   in_valid   in   2       per-slot enqueue request (2'b10 is ignored)
//   in_ready   out  1       room for two entries (from registered count)
//   in_pkt0/1  in   PKT_W   payloads
//   in_meta0/1 in   META_W  {is_priv, is_alu, rd, rj, rk}
//   out_valid  out  2       issue slots (2'b10 never driven)
//   out_ready  in   1       downstream accepts all valid slots
//   out_pkt0/1 out  PKT_W   issued payloads (zero when not issuing)
//   out_meta0/1 out META_W  issued metadata (zero when not issuing)
//   count      out  CNT_W   current occupancy
//   dbg_state  out  1       FSM state (0 = RUN, 1 = HOLD)
//
// Handshake: an enqueue happens on a rising edge where in_ready=1 and
// in_valid[0]=1 (and no flush); an issue happens on a rising edge where
// out_valid[0]=1 and out_ready=1, popping every valid slot at once. All
// outputs are combinational from registered state only.
module issue_queue
    import issue_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PKT_W = 128
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     flush,
    input  logic [1:0]               in_valid,
    output logic                     in_ready,
    input  logic [PKT_W-1:0]         in_pkt0,
    input  logic [PKT_W-1:0]         in_pkt1,
    input  logic [META_W-1:0]        in_meta0,
    input  logic [META_W-1:0]        in_meta1,
    output logic [1:0]               out_valid,
    input  logic                     out_ready,
    output logic [PKT_W-1:0]         out_pkt0,
    output logic [PKT_W-1:0]         out_pkt1,
    output logic [META_W-1:0]        out_meta0,
    output logic [META_W-1:0]        out_meta1,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     dbg_state
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Storage (not reset: contents are meaningless while count is zero)
    logic [PKT_W-1:0]  pkt_q  [DEPTH];
    logic [META_W-1:0] meta_q [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    iq_state_e        state_q, state_d;

    logic [PTR_W-1:0]  head1, tail1;
    logic [META_W-1:0] head_meta0, head_meta1;
    logic              dual_ok;
    logic              slot0_ok, slot1_ok;
    logic              push_en, pop_en;
    logic [1:0]        push_n, pop_n;

    assign head1 = head_q + PTR_W'(1);
    assign tail1 = tail_q + PTR_W'(1);

    assign head_meta0 = meta_q[head_q];
    assign head_meta1 = meta_q[head1];

    issue_pair_check u_pair_check (
        .meta0   (head_meta0),
        .meta1   (head_meta1),
        .dual_ok (dual_ok)
    );

    // ---------------- enqueue side ----------------
    // Readiness ignores same-cycle pops so it depends on registers only.
    assign in_ready = (count_q <= CNT_W'(DEPTH - 2));
    // in_valid[0]=0 covers both "no request" and the illegal 2'b10.
    assign push_en  = in_ready && in_valid[0] && !flush;
    assign push_n   = !push_en    ? 2'd0 :
                      in_valid[1] ? 2'd2 : 2'd1;

    // ---------------- issue side ----------------
    assign slot0_ok  = (state_q == ST_RUN) && (count_q != '0);
    assign slot1_ok  = slot0_ok && (count_q >= CNT_W'(2)) && dual_ok;
    assign out_valid = {slot1_ok, slot0_ok};

    assign out_pkt0  = slot0_ok ? pkt_q[head_q] : {PKT_W{NOP_BIT}};
    assign out_meta0 = slot0_ok ? head_meta0    : NOP_META;
    assign out_pkt1  = slot1_ok ? pkt_q[head1]  : {PKT_W{NOP_BIT}};
    assign out_meta1 = slot1_ok ? head_meta1    : NOP_META;

    assign pop_en = out_ready && slot0_ok && !flush;
    assign pop_n  = !pop_en  ? 2'd0 :
                    slot1_ok ? 2'd2 : 2'd1;

    assign count     = count_q;
    assign dbg_state = state_q;

    // ---------------- next state ----------------
    always_comb begin
        head_d  = head_q + PTR_W'(pop_n);
        tail_d  = tail_q + PTR_W'(push_n);
        count_d = count_q + CNT_W'(push_n) - CNT_W'(pop_n);
        state_d = state_q;
        case (state_q)
            // A privileged op leaving slot0 blocks issue for one cycle so
            // the next instruction sees its side effects.
            ST_RUN:  if (pop_en && meta_priv(head_meta0)) state_d = ST_HOLD;
            ST_HOLD: state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            state_d = ST_RUN;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            state_q <= ST_RUN;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) begin
            pkt_q[tail_q]  <= in_pkt0;
            meta_q[tail_q] <= in_meta0;
            if (in_valid[1]) begin
                pkt_q[tail1]  <= in_pkt1;
                meta_q[tail1] <= in_meta1;
            end
        end
    end

endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue (DEPTH=8, PKT_W=16). The stimulus process
// pushes each hand-computed issue bundle into exp_q; an independent monitor
// pops and compares whenever the DUT issues.
module tb_issue_queue;

    localparam int DEPTH = 8;
    localparam int PKT_W = 16;
    localparam int W     = 2 + 17 + 17 + PKT_W + PKT_W;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic             flush;
    logic [1:0]       in_valid;
    logic             in_ready;
    logic [PKT_W-1:0] in_pkt0, in_pkt1;
    logic [16:0]      in_meta0, in_meta1;
    logic [1:0]       out_valid;
    logic             out_ready;
    logic [PKT_W-1:0] out_pkt0, out_pkt1;
    logic [16:0]      out_meta0, out_meta1;
    logic [3:0]       count;
    logic             dbg_state;

    issue_queue #(.DEPTH(DEPTH), .PKT_W(PKT_W)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pkt0   (in_pkt0),
        .in_pkt1   (in_pkt1),
        .in_meta0  (in_meta0),
        .in_meta1  (in_meta1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pkt0  (out_pkt0),
        .out_pkt1  (out_pkt1),
        .out_meta0 (out_meta0),
        .out_meta1 (out_meta1),
        .count     (count),
        .dbg_state (dbg_state)
    );

    int n_chk  = 0;
    int n_fail = 0;
    logic [W-1:0] exp_q[$];

    // ---------------- helpers ----------------
    function automatic logic [16:0] mk(input logic priv, input logic alu,
                                       input logic [4:0] rd, input logic [4:0] rj,
                                       input logic [4:0] rk);
        return {priv, alu, rd, rj, rk};
    endfunction

    function automatic logic [W-1:0] dual(input logic [16:0] m0, input logic [16:0] m1,
                                          input logic [PKT_W-1:0] p0, input logic [PKT_W-1:0] p1);
        return {2'b11, m0, m1, p0, p1};
    endfunction

    function automatic logic [W-1:0] single(input logic [16:0] m0, input logic [PKT_W-1:0] p0);
        return {2'b01, m0, 17'd0, p0, 16'd0};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input logic [1:0] v, input logic [16:0] m0, input logic [16:0] m1,
                       input logic [PKT_W-1:0] p0, input logic [PKT_W-1:0] p1);
        in_valid = v;
        in_meta0 = m0;
        in_meta1 = m1;
        in_pkt0  = p0;
        in_pkt1  = p1;
        step();
        in_valid = 2'b00;
        in_meta0 = '0;
        in_meta1 = '0;
        in_pkt0  = '0;
        in_pkt1  = '0;
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rstn && !flush && out_ready && out_valid != 2'b00) begin
            logic [W-1:0] got;
            logic [W-1:0] expv;
            got = {out_valid, out_meta0, out_meta1, out_pkt0, out_pkt1};
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL issue_unexpected: got %0h expected nothing (t=%0t)", got, $time);
            end else begin
                expv = exp_q.pop_front();
                if (got !== expv) begin
                    n_fail++;
                    $display("FAIL issue_bundle: got %0h expected %0h (t=%0t)", got, expv, $time);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [16:0]      m0, m1;
    logic [PKT_W-1:0] p0, p1;

    initial begin
        rstn = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_valid = 2'b00; in_meta0 = '0; in_meta1 = '0; in_pkt0 = '0; in_pkt1 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // Independent ALU pair issues together and drains the same cycle.
        out_ready = 1'b1;
        m0 = mk(0, 1, 5'd1, 5'd2, 5'd3); p0 = 16'hA001;
        m1 = mk(0, 1, 5'd4, 5'd5, 5'd6); p1 = 16'hA002;
        exp_q.push_back(dual(m0, m1, p0, p1));
        enq(2'b11, m0, m1, p0, p1);
        chk("pair_count", 32'(count), 32'd2);
        chk("pair_valid", 32'(out_valid), 32'd3);
        step();
        chk("pair_drained", 32'(count), 32'd0);

        // RAW dependency: rd0=1 read as rj1 -> two single issues.
        m0 = mk(0, 1, 5'd1, 5'd2, 5'd3); p0 = 16'hA011;
        m1 = mk(0, 1, 5'd5, 5'd1, 5'd4); p1 = 16'hA012;
        exp_q.push_back(single(m0, p0));
        exp_q.push_back(single(m1, p1));
        enq(2'b11, m0, m1, p0, p1);
        chk("raw_valid_1st", 32'(out_valid), 32'd1);
        chk("raw_pkt1_nop", 32'(out_pkt1), 32'd0);
        step();
        chk("raw_valid_2nd", 32'(out_valid), 32'd1);
        step();
        chk("raw_drained", 32'(count), 32'd0);

        // rd1 = 0 forbids pairing.
        m0 = mk(0, 1, 5'd3, 5'd0, 5'd0); p0 = 16'hA021;
        m1 = mk(0, 1, 5'd0, 5'd7, 5'd8); p1 = 16'hA022;
        exp_q.push_back(single(m0, p0));
        exp_q.push_back(single(m1, p1));
        enq(2'b11, m0, m1, p0, p1);
        step();
        step();
        chk("rd0_drained", 32'(count), 32'd0);

        // Privileged op: issues alone, one HOLD cycle, then the ALU op.
        m0 = mk(1, 0, 5'd7, 5'd0, 5'd0); p0 = 16'hA031;
        m1 = mk(0, 1, 5'd9, 5'd1, 5'd2); p1 = 16'hA032;
        exp_q.push_back(single(m0, p0));
        exp_q.push_back(single(m1, p1));
        enq(2'b11, m0, m1, p0, p1);
        chk("priv_valid", 32'(out_valid), 32'd1);
        step();
        chk("hold_valid", 32'(out_valid), 32'd0);
        chk("hold_state", 32'(dbg_state), 32'd1);
        chk("hold_count", 32'(count), 32'd1);
        step();
        chk("after_hold_valid", 32'(out_valid), 32'd1);
        chk("after_hold_state", 32'(dbg_state), 32'd0);
        step();
        chk("priv_drained", 32'(count), 32'd0);

        // Illegal in_valid=2'b10 is ignored.
        enq(2'b10, mk(0, 1, 5'd1, 5'd0, 5'd0), mk(0, 1, 5'd2, 5'd0, 5'd0), 16'hDEAD, 16'hBEEF);
        chk("ivalid10_count", 32'(count), 32'd0);
        chk("ivalid10_valid", 32'(out_valid), 32'd0);

        // Flush the empty queue so the fill below starts from pointer 0.
        flush = 1'b1;
        step();
        flush = 1'b0;

        // Fill to DEPTH with four pairs, then four dual pops; pointers wrap.
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            m0 = mk(0, 1, 5'(2 * k + 1), 5'd0, 5'd0); p0 = 16'hB000 + 16'(2 * k);
            m1 = mk(0, 1, 5'(2 * k + 2), 5'd0, 5'd0); p1 = 16'hB001 + 16'(2 * k);
            exp_q.push_back(dual(m0, m1, p0, p1));
            enq(2'b11, m0, m1, p0, p1);
            chk("fill_count", 32'(count), 32'(2 * (k + 1)));
            chk("fill_in_ready", 32'(in_ready), (k < 3) ? 32'd1 : 32'd0);
        end
        enq(2'b11, mk(0, 1, 5'd30, 5'd0, 5'd0), mk(0, 1, 5'd31, 5'd0, 5'd0), 16'hEEEE, 16'hEEEF);
        chk("full_blocked", 32'(count), 32'd8);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("drain_count", 32'(count), 32'(6 - 2 * k));
        end
        m0 = mk(0, 1, 5'd12, 5'd0, 5'd0); p0 = 16'hC001;
        exp_q.push_back(single(m0, p0));
        enq(2'b01, m0, '0, p0, '0);
        step();
        chk("wrap_drained", 32'(count), 32'd0);

        // count = DEPTH-1 refuses enqueue.
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++)
            enq(2'b11, mk(0, 1, 5'd1, 5'd0, 5'd0), mk(0, 1, 5'd2, 5'd0, 5'd0), 16'h1111, 16'h2222);
        chk("c6_in_ready", 32'(in_ready), 32'd1);
        enq(2'b01, mk(0, 1, 5'd3, 5'd0, 5'd0), '0, 16'h3333, '0);
        chk("c7_count", 32'(count), 32'd7);
        chk("c7_in_ready", 32'(in_ready), 32'd0);
        enq(2'b11, mk(0, 1, 5'd4, 5'd0, 5'd0), mk(0, 1, 5'd5, 5'd0, 5'd0), 16'h4444, 16'h5555);
        chk("c7_blocked", 32'(count), 32'd7);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("c7_flushed", 32'(count), 32'd0);

        // count = 5, flush with simultaneous enqueue and pop request.
        enq(2'b11, mk(0, 1, 5'd1, 5'd0, 5'd0), mk(0, 1, 5'd2, 5'd0, 5'd0), 16'h6661, 16'h6662);
        enq(2'b11, mk(0, 1, 5'd3, 5'd0, 5'd0), mk(0, 1, 5'd4, 5'd0, 5'd0), 16'h6663, 16'h6664);
        enq(2'b01, mk(0, 1, 5'd5, 5'd0, 5'd0), '0, 16'h6665, '0);
        chk("c5_count", 32'(count), 32'd5);
        flush = 1'b1;
        out_ready = 1'b1;
        enq(2'b11, mk(0, 1, 5'd6, 5'd0, 5'd0), mk(0, 1, 5'd7, 5'd0, 5'd0), 16'h6666, 16'h6667);
        flush = 1'b0;
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        step();
        chk("flush_no_enq", 32'(count), 32'd0);

        // Reset while in HOLD with three entries.
        out_ready = 1'b0;
        m0 = mk(1, 0, 5'd3, 5'd0, 5'd0); p0 = 16'hD001;
        enq(2'b11, m0, mk(0, 1, 5'd4, 5'd0, 5'd0), p0, 16'hD002);
        enq(2'b11, mk(0, 1, 5'd5, 5'd0, 5'd0), mk(0, 1, 5'd6, 5'd0, 5'd0), 16'hD003, 16'hD004);
        exp_q.push_back(single(m0, p0));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("pre_rst_state", 32'(dbg_state), 32'd1);
        chk("pre_rst_count", 32'(count), 32'd3);
        rstn = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_state", 32'(dbg_state), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        out_ready = 1'b1;
        m0 = mk(0, 1, 5'd9, 5'd0, 5'd0); p0 = 16'hD101;
        exp_q.push_back(single(m0, p0));
        enq(2'b01, m0, '0, p0, '0);
        chk("post_rst_count", 32'(count), 32'd1);
        chk("post_rst_valid", 32'(out_valid), 32'd1);
        step();
        chk("post_rst_drained", 32'(count), 32'd0);

        // Bounded wait for any outstanding expected issues.
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/issue_queue.md
ISSUE_QUEUE -- requirements
Module: issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning number of queue entries; power of two, minimum 4.
REQ-002 SHALL have parameter PKT_W, default 128, meaning width of the opaque decoded-instruction payload carried per entry.
REQ-003 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-004 rstn  in  1  reset; asynchronous assert, active-low.
REQ-005 flush  in  1  discard all entries (branch mispredict or exception).
REQ-006 in_valid  in  2  enqueue request per decode slot; 2'b10 is illegal.
REQ-007 in_ready  out  1  queue accepts two entries this cycle.
REQ-008 in_pkt0, in_pkt1  in  PKT_W  payload per slot.
REQ-009 in_meta0, in_meta1  in  17  {is_priv, is_alu, rd[4:0], rj[4:0], rk[4:0]} per slot.
REQ-010 out_valid  out  2  issue slots valid; 2'b10 never driven.
REQ-011 out_ready  in  1  register stage allowin; pops all valid slots.
REQ-012 out_pkt0, out_pkt1  out  PKT_W  issued payloads.
REQ-013 out_meta0, out_meta1  out  17  issued metadata.
REQ-014 count  out  $clog2(DEPTH)+1  current occupancy.

Function
REQ-015 Storage: circular buffer, head/tail pointers $clog2(DEPTH) bits, wrapping modulo DEPTH.
REQ-016 Enqueue: in_ready = (DEPTH - count >= 2), from registered count, not reduced by same-cycle pops.
REQ-017 When in_ready and in_valid[0], slot0 written at tail; if also in_valid[1], slot1 at tail+1; tail advances by popcount.
REQ-018 in_valid=2'b10 SHALL be ignored entirely; no write, no pointer change.
REQ-019 Latency: an entry written at edge N is visible on out_* after edge N, earliest issue cycle N+1; no bypass.
REQ-020 Slot0 issues when count>=1 and state is RUN.
REQ-021 Slot1 issues only when count>=2, state RUN, both entries is_alu, neither is_priv, rd0!=0, rd1!=0, rd0!=rj1, rd0!=rk1, rd0!=rd1, rd1!=rj0, rd1!=rk0.
REQ-022 Unissued slot1 outputs SHALL be all-zero payload and meta (NOP); out_* when out_valid[0]=0 likewise zero.
REQ-023 Pop: on out_ready, head advances by popcount(out_valid); count updates by pushes minus pops in the same cycle.
REQ-024 FSM states RUN, HOLD; reset state RUN.
REQ-025 RUN->HOLD when a slot0 entry with is_priv=1 is popped; HOLD forces out_valid=2'b00.
REQ-026 HOLD->RUN after exactly one cycle regardless of out_ready; enqueue continues during HOLD.
REQ-027 flush: head, tail, count to 0, state to RUN at next edge; same-cycle enqueue and pop discarded; flush wins over all.
REQ-028 Full (count=DEPTH) and count=DEPTH-1: in_ready=0; empty: out_valid=2'b00.

Reset
REQ-029 On rstn low: head=0, tail=0, count=0, state=RUN, hence out_valid=2'b00, in_ready=1; entry storage not reset.
REQ-030 Reset mid-operation SHALL discard all contents immediately; first enqueue accepted on the first edge after rstn deasserts.

Structure
REQ-031 Meta field offsets, META_W=17, FSM state encoding and the NOP constant SHALL live in the shared define package.
REQ-032 Pairing check (REQ-021) SHALL be one combinational sub-module, issue_pair_check, taking both meta words, returning dual_ok.
REQ-033 Storage, pointers and FSM remain in issue_queue; all outputs combinational from registered state only.

Verification
REQ-034 Enqueue ALU pair rd=1/rj=2/rk=3 and rd=4/rj=5/rk=6, out_ready=1 -> next cycle out_valid=2'b11, count back to 0.
REQ-035 Enqueue rd=1 then rj=1 -> out_valid=2'b01 twice on consecutive cycles, out_pkt1 zero on first.
REQ-036 Enqueue priv then ALU -> priv issued alone, one cycle out_valid=2'b00 (HOLD), ALU issued on third cycle.
REQ-037 DEPTH=8, out_ready=0, enqueue four pairs -> count=8, in_ready=0 from count=7; then 4 dual pops, tail/head wrap to 0.
REQ-038 count=5, assert flush with in_valid=2'b11 -> next cycle count=0, out_valid=2'b00, in_ready=1.
REQ-039 Drop rstn with count=3 in HOLD -> immediately out_valid=2'b00, count=0; resumes RUN after release.
